uart_tx_scheduler: RTL and testbench
====================================

Name: uart_tx_scheduler

Overview:
Round-robin scheduler that shares the single UART transmitter (TX) between NUM_REQ byte producers. It captures one byte from the winning requester and fires a one-cycle tx_en with data into TX. TX has no busy output, so the scheduler times the frame itself by counting clocks. It then holds off the next launch until the frame plus an inter-frame gap has elapsed. It sits between the system's byte sources and TX's tx_en/data_in inputs.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CLKS_PER_BIT, 16, clock cycles per UART bit; must match TX configuration (>=1)
FRAME_BITS, 10, bits per frame: start + 8 data + stop
GAP_CYCLES, 2, idle clocks inserted after each frame (0 allowed)

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester "byte pending"; held until granted
req_data  in  8*NUM_REQ  byte of requester i at bits [8*i+7:8*i]
grant  out  NUM_REQ  one-hot, one-cycle pulse: byte of that requester captured
grant_id  out  3  index of last granted requester (valid from first grant)
tx_en  out  1  one-cycle launch strobe to TX
data_out  out  8  byte to TX data_in; stable from launch until next launch
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (sampled on clock edge with reset=1):
  - state=IDLE, tx_en=0, grant=0, grant_id=0, data_out=0, busy=0.
  - Round-robin pointer=0, frame counter=0.
  - Reset mid-frame abandons the frame. No grant or tx_en is issued in the reset cycle.
- Constant FRAME_CYCLES = FRAME_BITS*CLKS_PER_BIT. Counter width = clog2(FRAME_CYCLES), minimum 1.
- State machine: IDLE -> WAIT -> GAP -> IDLE. GAP is skipped when GAP_CYCLES=0.
- IDLE:
  - On an edge where req != 0, the winner is the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Registered results in the next cycle:
    - tx_en=1 and grant[w]=1 for exactly one cycle.
    - data_out=req_data[w], grant_id=w.
    - pointer=(w+1) mod NUM_REQ.
    - counter=FRAME_CYCLES-1, state=WAIT.
  - req=0: stay in IDLE, outputs hold; tx_en and grant stay 0.
- WAIT:
  - The counter decrements each edge.
  - On the edge where counter==0: if GAP_CYCLES>0, go to GAP with counter=GAP_CYCLES-1; otherwise go to IDLE.
  - WAIT lasts FRAME_CYCLES cycles, including the tx_en cycle.
- GAP: same countdown; go to IDLE when counter==0.
- Launch period for continuous requests is FRAME_CYCLES+GAP_CYCLES+1 cycles: IDLE is always one arbitration cycle.
- req is ignored outside IDLE. No request is lost: a requester keeps req high until it sees its grant pulse.
- Requester handshake:
  - req_data must be stable while req=1.
  - A requester may present a new byte with req high in the cycle after its grant. Fairness guarantees it cannot win again until every other active requester has been served.
- Simultaneous requests are resolved solely by the pointer. Starvation-free: at most NUM_REQ-1 frames wait per requester.
- data_out holds the last launched byte until the next grant. It never changes outside a tx_en cycle.
- busy is combinational from state and equals 1 in WAIT and GAP, including the tx_en cycle.
- grant and tx_en are always asserted in the same cycle. A grant without tx_en, or the reverse, is illegal.

Test Plan:
- Reset, no requests: hold 20 cycles -> tx_en, grant, busy stay 0; data_out=0x00.
- Single requester (CLKS_PER_BIT=4, GAP_CYCLES=2): req[0]=1 with byte 0xC9 -> one cycle later tx_en=1, grant=0001, data_out=0xC9. busy stays high 42 cycles (40 WAIT + 2 GAP).
- Continuous contention: req=1111 with bytes 0x11/0x22/0x33/0x44, each requester re-raising after its grant -> launches in order 0,1,2,3,0 with 0x11,0x22,0x33,0x44. Consecutive tx_en exactly 43 cycles apart.
- Pointer wrap: after requester 3 is served, assert req=1001 -> requester 0 wins, then requester 3; grant_id sequence 0,3.
- Late request: raise req[2] mid-WAIT -> no grant until the IDLE cycle. Grant arrives exactly one cycle after the GAP ends; data_out unchanged until then.
- Reset mid-operation: assert reset at cycle 15 of WAIT -> next cycle busy=0, state IDLE, pointer 0. With req=0110 held after reset release, requester 1 is granted first.

Source files
------------

// File: rtl/uart_tx_scheduler_if.sv
// Byte-producer / TX-launch bundle shared by the scheduler and whoever drives it.
// The scheduler takes the slave side; the producers/TX-facing environment takes the master side.
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   grant;
  logic [2:0]           grant_id;
  logic                 tx_en;
  logic [7:0]           data_out;
  logic                 busy;

  modport slave (
    input  req, req_data,
    output grant, grant_id, tx_en, data_out, busy
  );

  modport master (
    output req, req_data,
    input  grant, grant_id, tx_en, data_out, busy
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter that feeds one UART transmitter, timing each frame plus
// an inter-frame gap by clock counting because the transmitter has no busy flag.
module uart_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int FRAME_BITS   = 10,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  uart_tx_scheduler_if.slave   bus
);

  localparam int FRAME_CYCLES = FRAME_BITS * CLKS_PER_BIT;
  localparam int CW           = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int PW           = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [2:0]          gid_q, gid_d;
  logic                tx_en_q, tx_en_d;
  logic [7:0]          data_q, data_d;

  logic                found;
  int                  win;

  // First pending requester at or after the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && bus.req[(int'(ptr_q) + k) % NUM_REQ]) begin
        found = 1'b1;
        win   = (int'(ptr_q) + k) % NUM_REQ;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = '0;
    gid_d   = gid_q;
    tx_en_d = 1'b0;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          tx_en_d = 1'b1;
          grant_d = NUM_REQ'(1) << win;
          gid_d   = 3'(win);
          data_d  = bus.req_data[8*win +: 8];
          ptr_d   = PW'((win + 1) % NUM_REQ);
          cnt_d   = CW'(FRAME_CYCLES - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            cnt_d   = CW'(GAP_CYCLES - 1);
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset abandons any frame in flight and clears every output.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
      gid_q   <= '0;
      tx_en_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      tx_en_q <= tx_en_d;
      data_q  <= data_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.grant_id = gid_q;
  assign bus.tx_en    = tx_en_q;
  assign bus.data_out = data_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with CLKS_PER_BIT=4, GAP_CYCLES=2 (43-cycle launch period);
// expected launches are queued as stimulus is applied and compared when tx_en appears.
module tb_uart_tx_scheduler;

  localparam int NUM_REQ = 4;
  localparam int PERIOD  = 43;

  typedef struct {
    int         id;
    logic [7:0] b;
  } exp_t;

  logic clock;
  logic reset;
  int   cycle;
  int   total;
  int   passed;
  exp_t sb[$];

  uart_tx_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_scheduler #(
    .NUM_REQ      (NUM_REQ),
    .CLKS_PER_BIT (4),
    .FRAME_BITS   (10),
    .GAP_CYCLES   (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clock);
    cycle++;
  endtask

  task automatic push(input int id, input logic [7:0] b);
    exp_t e;
    e.id = id;
    e.b  = b;
    sb.push_back(e);
  endtask

  // Waits for the next launch, checking nothing moves beforehand, then scores it.
  task automatic wait_launch(input string tag, input int budget, output int at);
    logic [7:0] held;
    int         viol;
    bit         seen;
    exp_t       e;
    held = bus.data_out;
    viol = 0;
    seen = 1'b0;
    at   = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (bus.tx_en === 1'b1) begin
        seen = 1'b1;
        at   = cycle;
      end else if (bus.grant !== '0 || bus.data_out !== held) begin
        viol++;
      end
    end
    check({tag, "_hold"}, 32'(viol), 32'd0);
    check({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      if (sb.size() == 0) begin
        check({tag, "_unexpected"}, 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check({tag, "_grant"}, 32'(bus.grant), 32'(4'b0001 << e.id));
        check({tag, "_id"},    32'(bus.grant_id), 32'(e.id));
        check({tag, "_data"},  32'(bus.data_out), 32'(e.b));
      end
    end
  endtask

  initial begin
    int t[5];
    int tl;
    int activity;
    int bcnt;
    bit dropped;

    cycle  = 0;
    total  = 0;
    passed = 0;
    reset  = 1'b1;
    bus.req      = '0;
    bus.req_data = '0;
    tick();
    tick();

    check("rst_tx_en",    32'(bus.tx_en),    32'd0);
    check("rst_grant",    32'(bus.grant),    32'd0);
    check("rst_grant_id", 32'(bus.grant_id), 32'd0);
    check("rst_data",     32'(bus.data_out), 32'd0);
    check("rst_busy",     32'(bus.busy),     32'd0);
    reset = 1'b0;

    // Idle with no requests.
    activity = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.tx_en !== 1'b0 || bus.grant !== '0 || bus.busy !== 1'b0) activity++;
    end
    check("idle_activity", 32'(activity), 32'd0);
    check("idle_data",     32'(bus.data_out), 32'd0);

    // Single requester: latency one cycle, then 42 busy cycles.
    bus.req_data[7:0] = 8'hC9;
    bus.req           = 4'b0001;
    push(0, 8'hC9);
    wait_launch("single", 1, tl);
    bus.req = 4'b0000;
    check("single_busy_at_launch", 32'(bus.busy), 32'd1);
    bcnt    = 1;
    dropped = 1'b0;
    for (int i = 0; i < 100 && !dropped; i++) begin
      tick();
      if (bus.busy === 1'b1) bcnt++;
      else dropped = 1'b1;
    end
    check("single_busy_len", 32'(bcnt), 32'd42);
    check("single_data_held", 32'(bus.data_out), 32'hC9);
    check("single_tx_en_idle", 32'(bus.tx_en), 32'd0);

    // Contention from a fresh pointer.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.req      = 4'b1111;
    push(0, 8'h11);
    push(1, 8'h22);
    push(2, 8'h33);
    push(3, 8'h44);
    push(0, 8'h11);
    for (int i = 0; i < 5; i++) begin
      wait_launch("contend", (i == 0) ? 5 : 60, t[i]);
    end
    for (int i = 1; i < 5; i++) begin
      check("contend_period", 32'(t[i] - t[i-1]), 32'(PERIOD));
    end

    // Pointer wrap: serve 3, then 1001 must go 0 then 3.
    bus.req = 4'b1000;
    push(3, 8'h44);
    wait_launch("wrap_pre", 60, tl);
    bus.req = 4'b1001;
    push(0, 8'h11);
    push(3, 8'h44);
    wait_launch("wrap_a", 60, tl);
    bus.req = 4'b1000;
    wait_launch("wrap_b", 60, tl);
    bus.req = 4'b0000;

    // Late request raised mid-WAIT launches exactly one period after the last.
    for (int i = 0; i < 10; i++) tick();
    bus.req_data[23:16] = 8'h5A;
    bus.req             = 4'b0100;
    push(2, 8'h5A);
    wait_launch("late", 60, t[0]);
    check("late_timing", 32'(t[0] - tl), 32'(PERIOD));
    bus.req = 4'b0000;

    // Reset during WAIT.
    for (int i = 0; i < 13; i++) tick();
    check("mid_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_busy",  32'(bus.busy),     32'd0);
    check("mid_rst_tx_en", 32'(bus.tx_en),    32'd0);
    check("mid_rst_id",    32'(bus.grant_id), 32'd0);
    check("mid_rst_data",  32'(bus.data_out), 32'd0);
    bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.req      = 4'b0110;
    tick();
    check("mid_rst_no_grant", 32'(bus.grant), 32'd0);
    check("mid_rst_no_tx_en", 32'(bus.tx_en), 32'd0);
    reset = 1'b0;
    push(1, 8'h22);
    wait_launch("post_rst_a", 3, t[1]);
    bus.req = 4'b0100;
    push(2, 8'h33);
    wait_launch("post_rst_b", 60, t[2]);
    check("post_rst_period", 32'(t[2] - t[1]), 32'(PERIOD));
    bus.req = 4'b0000;

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
